// File: rtl/aes_cbc_dec_ctrl.sv
// rtl/aes_cbc_dec_ctrl.sv - AES-128 CBC decrypt controller: key load, word collect, core handshake, chained output
module aes_cbc_dec_ctrl #(
  parameter int KEY_WAIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_start,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         core_kld,
  output logic         core_ld,
  output logic [127:0] core_key,
  output logic [127:0] core_text_in,
  input  logic         core_done,
  input  logic [127:0] core_text_out,
  output logic         key_ready,
  output logic         busy,
  output logic [15:0]  blk_cnt
);

  typedef enum logic [2:0] {NOKEY, KEYLD, KEYWAIT, COLLECT, LOAD, RUN, OUTPUT} state_t;

  state_t       state, state_next;
  logic [1:0]   rst_sync;
  logic         run_en;
  logic [7:0]   wait_cnt;
  logic [1:0]   word_cnt;
  logic [1:0]   out_idx;
  logic [127:0] buffer;
  logic [127:0] chain;
  logic [127:0] plain;
  logic         key_acc, take_word, done_cap, out_fire;

  // Reset asserts immediately but releases through two flops, so the FSM
  // cannot move before the second clock edge after deassertion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run_en = rst_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= NOKEY;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_word  = 1'b0;
    done_cap   = 1'b0;
    out_fire   = 1'b0;
    key_acc    = run_en && key_start &&
                 (state == NOKEY || (state == COLLECT && word_cnt == 2'd0));
    in_ready   = (state == COLLECT) && !key_acc;
    if (run_en) begin
      case (state)
        NOKEY:   if (key_acc) state_next = KEYLD;
        KEYLD:   state_next = KEYWAIT;
        KEYWAIT: if (wait_cnt == 8'd1) state_next = COLLECT;
        COLLECT: begin
          if (key_acc) begin
            state_next = KEYLD;
          end else if (in_valid) begin
            take_word = 1'b1;
            if (word_cnt == 2'd3) state_next = LOAD;
          end
        end
        LOAD:    state_next = RUN;
        RUN: begin
          if (core_done) begin
            done_cap   = 1'b1;
            state_next = OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_fire = 1'b1;
            if (out_idx == 2'd3) state_next = COLLECT;
          end
        end
        default: state_next = NOKEY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt     <= 8'd0;
      word_cnt     <= 2'd0;
      out_idx      <= 2'd0;
      buffer       <= 128'd0;
      chain        <= 128'd0;
      plain        <= 128'd0;
      core_key     <= 128'd0;
      core_text_in <= 128'd0;
      key_ready    <= 1'b0;
      blk_cnt      <= 16'd0;
    end else begin
      if (key_acc) begin
        core_key  <= key_in;
        chain     <= iv_in;
        blk_cnt   <= 16'd0;
        key_ready <= 1'b0;
      end
      if (state == KEYLD) begin
        wait_cnt <= 8'(KEY_WAIT);
      end else if (state == KEYWAIT) begin
        wait_cnt <= wait_cnt - 8'd1;
        if (wait_cnt == 8'd1) key_ready <= 1'b1;
      end
      // The core sees the assembled block already during the LOAD cycle.
      if (take_word) begin
        buffer   <= {buffer[95:0], in_data};
        word_cnt <= word_cnt + 2'd1;
        if (word_cnt == 2'd3) core_text_in <= {buffer[95:0], in_data};
      end
      if (done_cap) begin
        plain   <= core_text_out ^ chain;
        chain   <= buffer;
        out_idx <= 2'd0;
      end
      if (out_fire) begin
        out_idx <= out_idx + 2'd1;
        if (out_idx == 2'd3) blk_cnt <= blk_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    out_data = 32'd0;
    if (state == OUTPUT) begin
      case (out_idx)
        2'd0:    out_data = plain[127:96];
        2'd1:    out_data = plain[95:64];
        2'd2:    out_data = plain[63:32];
        default: out_data = plain[31:0];
      endcase
    end
  end

  assign out_valid = (state == OUTPUT);
  assign core_kld  = (state == KEYLD);
  assign core_ld   = (state == LOAD);
  assign busy      = !(state == NOKEY || (state == COLLECT && word_cnt == 2'd0));

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// tb/tb_aes_cbc_dec_ctrl.sv - directed bench with behavioural core and output scoreboard
module tb_aes_cbc_dec_ctrl;
  localparam int KW = 16;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0, rst = 1'b0;
  logic         key_start = 1'b0;
  logic [127:0] key_in = '0, iv_in = '0;
  logic         in_valid = 1'b0, in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid, out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         core_kld, core_ld;
  logic [127:0] core_key, core_text_in;
  logic         core_done = 1'b0;
  logic [127:0] core_text_out = '0;
  logic         key_ready, busy;
  logic [15:0]  blk_cnt;

  aes_cbc_dec_ctrl #(.KEY_WAIT(KW)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_in(key_in), .iv_in(iv_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_kld(core_kld), .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
    .core_done(core_done), .core_text_out(core_text_out),
    .key_ready(key_ready), .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int kld_cnt = 0, ld_cnt = 0, ov_cnt = 0, both_cnt = 0, done_cnt = 0;
  logic [31:0]  sb_q[$];
  logic [127:0] chain_m = '0;
  int           core_pend = 0;
  logic [127:0] core_txt = '0;

  // Stand-in for the AES core: the known vector decrypts properly, anything else inverts.
  function automatic logic [127:0] fake_dec(input logic [127:0] t);
    return (t == C0) ? P0 : ~t;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_done) core_done = 1'b0;
    if (core_pend > 0) begin
      core_pend--;
      if (core_pend == 0) begin
        core_done     = 1'b1;
        core_text_out = fake_dec(core_txt);
        done_cnt++;
      end
    end
    if (core_ld) begin
      core_pend = 6;
      core_txt  = core_text_in;
    end
  end

  always @(negedge clk) begin
    #1;
    if (core_kld) kld_cnt++;
    if (core_ld) ld_cnt++;
    if (core_kld && core_ld) both_cnt++;
    if (out_valid) ov_cnt++;
    if (out_valid && out_ready) begin
      if (sb_q.size() > 0) check("sb_word", {96'd0, out_data}, {96'd0, sb_q.pop_front()});
      else begin
        n_cmp++; n_fail++;
        $error("FAIL sb_word: observed %h expected none", out_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] iv);
    int t;
    @(negedge clk);
    key_start = 1'b1; key_in = k; iv_in = iv;
    @(negedge clk);
    key_start = 1'b0;
    chain_m = iv;
    t = 0;
    while (!key_ready && t < 300) begin @(negedge clk); t++; end
    check("key_ready", {127'd0, key_ready}, 128'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    in_valid = 1'b1; in_data = w;
    #1;
    t = 0;
    while (!in_ready && t < 300) begin @(negedge clk); #1; t++; end
    check("in_accept", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] exp, input bit push);
    if (push) begin
      for (int i = 0; i < 4; i++) sb_q.push_back(exp[127-32*i -: 32]);
      chain_m = ct;
    end
    for (int i = 0; i < 4; i++) send_word(ct[127-32*i -: 32]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    check("drain", 128'(sb_q.size()), 128'd0);
    tick(2);
  endtask

  initial begin
    logic [127:0] ct, e;
    logic [31:0]  d;
    int k0, l0, o0, d0, lowc, t;

    tick(3); #1;
    check("rst_ctl", {122'd0, in_ready, out_valid, core_kld, core_ld, key_ready, busy}, 128'd0);
    check("rst_blk", {112'd0, blk_cnt}, 128'd0);
    check("rst_data", {96'd0, out_data}, 128'd0);
    check("rst_key", core_key, 128'd0);
    check("rst_text", core_text_in, 128'd0);

    // key_start on the first edge after release must not be taken
    @(negedge clk); rst = 1'b1; key_start = 1'b1; key_in = K0;
    @(negedge clk); key_start = 1'b0;
    tick(4);
    check("sync_release", 128'(kld_cnt), 128'd0);

    k0 = kld_cnt;
    load_key(K0, 128'd0);
    check("kld_once", 128'(kld_cnt - k0), 128'd1);
    check("core_key", core_key, K0);
    send_block(C0, P0, 1'b1);
    drain();
    check("blk_cnt_1", {112'd0, blk_cnt}, 128'd1);

    load_key(K0, {128{1'b1}});
    check("blk_clr", {112'd0, blk_cnt}, 128'd0);
    send_block(C0, 128'hffeeddccbbaa99887766554433221100, 1'b1);
    drain();
    check("blk_cnt_iv1", {112'd0, blk_cnt}, 128'd1);

    load_key(K0, 128'd0);
    send_block(C0, P0, 1'b1);
    send_block(C0, 128'h69d5c2eb2e2e624750541d3bbc692ba5, 1'b1);
    drain();
    check("blk_cnt_2", {112'd0, blk_cnt}, 128'd2);

    // Output back-pressure
    @(negedge clk); out_ready = 1'b0;
    ct = 128'h0123456789abcdef0011223344556677;
    e  = fake_dec(ct) ^ chain_m;
    send_block(ct, e, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    #1;
    check("stall_first", {96'd0, out_data}, {96'd0, e[127:96]});
    d = out_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("stall_hold", {94'd0, out_valid, in_ready, out_data}, {94'd0, 1'b1, 1'b0, d});
    end
    @(negedge clk); out_ready = 1'b1;
    drain();
    check("blk_cnt_3", {112'd0, blk_cnt}, 128'd3);

    // key_start with two words collected is ignored
    ct = 128'hfedcba98765432100f1e2d3c4b5a6978;
    e  = fake_dec(ct) ^ chain_m;
    for (int i = 0; i < 4; i++) sb_q.push_back(e[127-32*i -: 32]);
    chain_m = ct;
    send_word(ct[127:96]);
    send_word(ct[95:64]);
    k0 = kld_cnt;
    key_start = 1'b1; key_in = 128'h55; iv_in = 128'h66;
    @(negedge clk); key_start = 1'b0;
    tick(3);
    check("ks_ignored", {127'd0, key_ready, 96'd0, 32'(kld_cnt - k0)}, {127'd0, 1'b1, 128'd0});
    send_word(ct[63:32]);
    send_word(ct[31:0]);
    drain();
    check("key_kept", core_key, K0);

    // key_start wins over a simultaneous input word
    k0 = kld_cnt;
    @(negedge clk);
    key_start = 1'b1; key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    iv_in = 128'hcafef00d_12345678_9abcdef0_0badf00d;
    in_valid = 1'b1; in_data = 32'hdeadbeef;
    #1;
    check("ks_in_ready", {127'd0, in_ready}, 128'd0);
    @(negedge clk); key_start = 1'b0; in_valid = 1'b0;
    chain_m = 128'hcafef00d_12345678_9abcdef0_0badf00d;
    lowc = 1;
    while (!key_ready && lowc < 300) begin @(negedge clk); if (!key_ready) lowc++; end
    check("key_low_cycles", 128'(lowc), 128'(KW + 1));
    check("kld_pulse", 128'(kld_cnt - k0), 128'd1);
    check("core_key_new", core_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    ct = 128'h00000001000000020000000300000004;
    send_block(ct, fake_dec(ct) ^ chain_m, 1'b1);
    drain();
    check("blk_cnt_newkey", {112'd0, blk_cnt}, 128'd1);
    check("kld_ld_overlap", 128'(both_cnt), 128'd0);

    // Reset while the core is running
    l0 = ld_cnt;
    send_block(128'h11112222333344445555666677778888, 128'd0, 1'b0);
    t = 0;
    while (ld_cnt == l0 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk); rst = 1'b0; #1;
    check("rst_run_ctl", {122'd0, in_ready, out_valid, core_kld, core_ld, key_ready, busy}, 128'd0);
    check("rst_run_blk", {96'd0, out_data, blk_cnt[15:0]} , 128'd0);
    check("rst_run_regs", core_key | core_text_in, 128'd0);
    tick(2);
    @(negedge clk); rst = 1'b1;
    o0 = ov_cnt; l0 = ld_cnt; d0 = done_cnt;
    tick(20);
    check("late_done_seen", 128'(done_cnt > d0), 128'd1);
    check("late_done_ignored", 128'(ov_cnt - o0), 128'd0);
    check("no_ld_after_rst", 128'(ld_cnt - l0), 128'd0);
    check("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_cbc_dec_ctrl.md
AES_CBC_DEC_CTRL -- requirements
Module: aes_cbc_dec_ctrl

Interface
REQ-001 Parameter: KEY_WAIT, 16, cycles from core_kld pulse until the core key schedule is usable (range 12..255).
REQ-002 Port: clk  in  1  single clock, all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset.
REQ-004 Port: key_start  in  1  single-cycle request to load key_in and iv_in.
REQ-005 Port: key_in  in  128  AES-128 key, sampled when key_start is accepted.
REQ-006 Port: iv_in  in  128  CBC IV, sampled when key_start is accepted.
REQ-007 Port: in_valid / in_ready  in / out  1 / 1  ciphertext word handshake.
REQ-008 Port: in_data  in  32  ciphertext word; first word of a block = bits 127:96.
REQ-009 Port: out_valid / out_ready  out / in  1 / 1  plaintext word handshake.
REQ-010 Port: out_data  out  32  plaintext word; first word = bits 127:96.
REQ-011 Port: core_kld, core_ld  out  1 each  key-load and block-load pulses to the decrypt core.
REQ-012 Port: core_key, core_text_in  out  128 each  key and ciphertext to the core.
REQ-013 Port: core_done  in  1; core_text_out  in  128  core completion pulse and result.
REQ-014 Port: key_ready  out  1  key schedule valid; busy  out  1  state != IDLE/COLLECT-empty.
REQ-015 Port: blk_cnt  out  16  blocks fully output since last key_start, wraps 0xFFFF->0.

Function
REQ-016 States: NOKEY, KEYLD, KEYWAIT, COLLECT, LOAD, RUN, OUTPUT.
REQ-017 NOKEY: in_ready=0; key_start -> KEYLD.
REQ-018 Key acceptance: key_start accepted in NOKEY, or in COLLECT with word count 0; ignored in all other states/counts.
REQ-019 On accept: latch key_in -> core_key, iv_in -> chain register, clear blk_cnt, key_ready<=0.
REQ-020 KEYLD: core_kld=1 for exactly one cycle -> KEYWAIT; wait counter loaded with KEY_WAIT.
REQ-021 KEYWAIT: decrement each cycle; at 0 -> COLLECT, key_ready<=1.
REQ-022 COLLECT: in_ready=1 except in a cycle where key_start is accepted (key_start wins, word not taken).
REQ-023 Each in_valid&in_ready shifts in_data into a 128-bit buffer, MSW first; 2-bit word count increments.
REQ-024 Fourth accepted word -> LOAD; word count wraps to 0.
REQ-025 LOAD: core_text_in = buffer (held stable until next LOAD); core_ld=1 for exactly one cycle -> RUN.
REQ-026 RUN: in_ready=0; on core_done=1 capture plain = core_text_out XOR chain; chain <= buffer; -> OUTPUT.
REQ-027 core_done outside RUN is ignored.
REQ-028 OUTPUT: out_valid=1, out_data = word k of plain (k=0..3, MSW first); out_data stable while out_valid&!out_ready.
REQ-029 Word advances only on out_valid&out_ready; after word 3 accepted: blk_cnt+1, -> COLLECT.
REQ-030 First-cycle latency: out_valid rises the cycle after core_done is sampled high.
REQ-031 One block in flight; no input accepted from LOAD through end of OUTPUT.
REQ-032 core_kld and core_ld never asserted in the same cycle.

Reset
REQ-033 rst low asynchronously forces: state NOKEY, key_ready=0, busy=0, in_ready=0, out_valid=0, core_kld=0, core_ld=0, out_data=0, blk_cnt=0, word count 0.
REQ-034 Key, IV, chain, buffer registers cleared to 0 on reset.
REQ-035 Reset mid-block (any state) discards the block; no core_ld or out_valid until a new key_start and four input words.
REQ-036 Release of rst is synchronised: first state change occurs no earlier than the second clk edge after deassertion.

Verification
REQ-037 Key 000102030405060708090a0b0c0d0e0f, IV 0, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> output words 00112233 44556677 8899aabb ccddeeff; blk_cnt=1.
REQ-038 Same key/ciphertext, IV all-ones -> ffeeddcc bbaa9988 77665544 33221100.
REQ-039 IV 0, same ciphertext sent twice -> block 2 = 69d5c2eb 2e2e6247 50541d3b bc692ba5 (chain=first ciphertext).
REQ-040 out_ready held low 20 cycles during OUTPUT -> out_valid stays 1, out_data unchanged, in_ready=0.
REQ-041 key_start after 2 words in COLLECT -> ignored; key_start with count 0 and in_valid=1 same cycle -> word not taken, core_kld pulses once, key_ready low KEY_WAIT+1 cycles.
REQ-042 rst asserted in RUN -> all outputs at reset values immediately; later core_done produces no out_valid.
